// File: rtl/fp_multicycle_sequencer_if.sv
// Decode / fetch / FP-unit / write-back signal bundle for the multi-cycle FP sequencer.
interface fp_multicycle_sequencer_if;
    logic        issue_valid;
    logic        issue_op;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        halt;
    logic        fu_start;
    logic        fu_sel;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        busy;
    logic [31:0] stall_cycles;

    modport master (
        output issue_valid, issue_op, issue_rd, flush,
        input  halt, fu_start, fu_sel, wb_valid, wb_rd, busy, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_op, issue_rd, flush,
        output halt, fu_start, fu_sel, wb_valid, wb_rd, busy, stall_cycles
    );
endinterface

// File: rtl/fp_multicycle_sequencer.sv
// Sequences one multi-cycle FP op (SQRT/DIV): start pulse, fixed-latency count, write-back strobe.
// Optional halt-cycle counter enabled by defining FP_MC_PERF_CNT_EN.
module fp_multicycle_sequencer #(
    parameter int unsigned SQRT_LAT = 16,
    parameter int unsigned DIV_LAT  = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    fp_multicycle_sequencer_if.slave    bus
);
    localparam int unsigned MAX_LAT = (SQRT_LAT > DIV_LAT) ? SQRT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, RUN, WB} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fu_sel_q;
    logic [4:0]         wb_rd_q;
    logic               fu_start_q;
    logic               wb_valid_q;
    logic               busy_q;
    logic               accept;
    logic [CNT_W-1:0]   lat_m1;

    // Decode is frozen while RUN, so a new op can only be taken in IDLE or WB.
    assign accept = !reset && bus.issue_valid && !bus.flush && (state_q != RUN);
    assign lat_m1 = bus.issue_op ? CNT_W'(DIV_LAT - 1) : CNT_W'(SQRT_LAT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fu_sel_q   <= 1'b0;
            wb_rd_q    <= '0;
            fu_start_q <= 1'b0;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fu_start_q <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE, WB: begin
                    // wb_rd_q only changes after the edge, so the retiring rd stays visible in WB.
                    if (accept) begin
                        state_q    <= RUN;
                        fu_sel_q   <= bus.issue_op;
                        wb_rd_q    <= bus.issue_rd;
                        cnt_q      <= lat_m1;
                        fu_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        state_q    <= WB;
                        wb_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.halt     = ((state_q == RUN) && !reset) || accept;
    assign bus.fu_start = fu_start_q;
    assign bus.fu_sel   = fu_sel_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.busy     = busy_q;

`ifdef FP_MC_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles with fetch frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (bus.halt && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_fp_multicycle_sequencer.sv
// Self-checking bench for fp_multicycle_sequencer: timestamp model plus directed scenarios.
module tb_fp_multicycle_sequencer;
    localparam int unsigned SQRT_LAT = 16;
    localparam int unsigned DIV_LAT  = 12;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_multicycle_sequencer_if bus();

    fp_multicycle_sequencer #(.SQRT_LAT(SQRT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: each accepted op owns a RUN window [run_s, run_e]; write-back lands at run_e+1.
    int          run_s = -100;
    int          run_e = -100;
    logic        last_op = 1'b0;
    logic [4:0]  last_rd = 5'd0;
    logic [31:0] stall_exp = 32'd0;

    always @(negedge clk) begin : model_cmp
        logic running, acc, exp_halt;
        if (cyc >= 1) begin
            running  = (cyc >= run_s) && (cyc <= run_e);
            acc      = !reset && bus.issue_valid && !bus.flush && !running;
            exp_halt = acc || (running && !reset);
            chk("m_halt",     32'(bus.halt),     32'(exp_halt));
            chk("m_busy",     32'(bus.busy),     32'(running));
            chk("m_fu_start", 32'(bus.fu_start), 32'(cyc == run_s));
            chk("m_wb_valid", 32'(bus.wb_valid), 32'(cyc == run_e + 1));
            chk("m_fu_sel",   32'(bus.fu_sel),   32'(last_op));
            chk("m_wb_rd",    32'(bus.wb_rd),    32'(last_rd));
`ifdef FP_MC_PERF_CNT_EN
            chk("m_stall",    bus.stall_cycles,  stall_exp);
`else
            chk("m_stall",    bus.stall_cycles,  32'd0);
`endif
            if (reset) begin
                run_s = -100; run_e = -100;
                last_op = 1'b0; last_rd = 5'd0; stall_exp = 32'd0;
            end else begin
                if (exp_halt && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 32'd1;
                if (acc) begin
                    run_s   = cyc + 1;
                    run_e   = cyc + (bus.issue_op ? int'(DIV_LAT) : int'(SQRT_LAT));
                    last_op = bus.issue_op;
                    last_rd = bus.issue_rd;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic op, input logic [4:0] rd, input logic fl);
        bus.issue_valid = v; bus.issue_op = op; bus.issue_rd = rd; bus.flush = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (n) step();
    endtask

    // Follows an op accepted in the previous cycle until its write-back; optionally wiggles decode inputs.
    task automatic track(input logic [4:0] rd, input logic op, input int lat, input bit noisy);
        int n = 1, start_n = 0, halt_n = 0, wb_n = 0;
        while (wb_n == 0 && n <= 40) begin
            @(negedge clk);
            if (bus.fu_start && start_n == 0) begin
                start_n = n;
                chk("t_fu_sel", 32'(bus.fu_sel), 32'(op));
            end
            if (bus.halt) halt_n++;
            if (bus.wb_valid) begin
                wb_n = n;
                chk("t_wb_rd", 32'(bus.wb_rd), 32'(rd));
            end
            step();
            if (noisy && n + 1 <= lat) drive(n[0], ~op, 5'(n), n[1]);
            else drive(1'b0, 1'b0, 5'd0, 1'b0);
            n++;
        end
        chk("t_start_cycle", 32'(start_n), 32'd1);
        chk("t_wb_cycle",    32'(wb_n),    32'(lat + 1));
        chk("t_halt_cycles", 32'(halt_n),  32'(lat));
    endtask

    task automatic issue_and_track(input logic op, input logic [4:0] rd, input int lat, input bit noisy);
        drive(1'b1, op, rd, 1'b0);
        @(negedge clk);
        chk("t_halt_issue", 32'(bus.halt), 32'd1);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        track(rd, op, lat, noisy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int hcnt, seen;
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd31, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        step();
        reset = 1'b0;
        idle(2);

        // SQRT rd=5: 17 halt cycles total, start one cycle after issue, write-back 17 after issue.
        issue_and_track(1'b0, 5'd5, 16, 1'b0);
        idle(2);

        // DIV rd=9, then DIV rd=3 issued in its WB cycle.
        drive(1'b1, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        hcnt = bus.halt ? 1 : 0;
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (12) begin
            @(negedge clk);
            if (bus.halt) hcnt++;
            step();
        end
        drive(1'b1, 1'b1, 5'd3, 1'b0);
        @(negedge clk);
        chk("b2b_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("b2b_wb_rd",    32'(bus.wb_rd),    32'd9);
        if (bus.halt) hcnt++;
        chk("b2b_halt_cont", 32'(hcnt), 32'd14);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        track(5'd3, 1'b1, 12, 1'b0);
        idle(2);

        // issue with flush in IDLE is dropped.
        drive(1'b1, 1'b1, 5'd4, 1'b1);
        @(negedge clk);
        chk("fl_halt", 32'(bus.halt), 32'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("fl_fu_start", 32'(bus.fu_start), 32'd0);
        chk("fl_busy",     32'(bus.busy),     32'd0);
        step();

        // Flushed issue in WB: strobe still retires, nothing new starts.
        drive(1'b1, 1'b1, 5'd1, 1'b0);
        @(negedge clk);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (12) begin @(negedge clk); step(); end
        drive(1'b1, 1'b0, 5'd2, 1'b1);
        @(negedge clk);
        chk("flwb_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("flwb_wb_rd",    32'(bus.wb_rd),    32'd1);
        chk("flwb_halt",     32'(bus.halt),     32'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("flwb_busy", 32'(bus.busy), 32'd0);
        step();

        // Reset in RUN cycle 5 aborts the op silently.
        drive(1'b1, 1'b1, 5'd7, 1'b0);
        @(negedge clk);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (4) begin @(negedge clk); step(); end
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("ra_halt",     32'(bus.halt),     32'd0);
        chk("ra_busy",     32'(bus.busy),     32'd0);
        chk("ra_fu_start", 32'(bus.fu_start), 32'd0);
        chk("ra_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("ra_wb_rd",    32'(bus.wb_rd),    32'd0);
        chk("ra_fu_sel",   32'(bus.fu_sel),   32'd0);
        step();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wb_valid) seen++;
            step();
        end
        chk("ra_no_wb", 32'(seen), 32'd0);

        // Decode noise during RUN must not disturb the in-flight SQRT.
        issue_and_track(1'b0, 5'd12, 16, 1'b1);
        idle(2);

`ifdef FP_MC_PERF_CNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(1);
        issue_and_track(1'b0, 5'd6, 16, 1'b0);
        idle(3);
        issue_and_track(1'b0, 5'd8, 16, 1'b0);
        @(negedge clk);
        chk("perf_34", bus.stall_cycles, 32'd34);
        step();
        #1;
        force dut.stall_q = 32'hFFFF_FFFE;
        stall_exp = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        issue_and_track(1'b1, 5'd2, 12, 1'b0);
        @(negedge clk);
        chk("perf_sat", bus.stall_cycles, 32'hFFFF_FFFF);
        step();
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
